// File: rtl/dcache_wbuf_if.sv
// AXI-style write channel bundle (AW/W/B) shared by the D-cache side and the
// arbiter side of the write-back buffer.
interface dcache_wbuf_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/dcache_wbuf.sv
// Write-back buffer: captures D-cache write bursts, acknowledges them locally,
// drains them in FIFO order downstream and flags reads that hit a buffered line.
module dcache_wbuf #(
  parameter int LINE_WORDS = 8,
  parameter int DEPTH      = 2
) (
  input  logic                aclk,
  input  logic                aresetn,
  dcache_wbuf_if.slave        s_axi,
  dcache_wbuf_if.master       m_axi,
  input  logic [31:0]         chk_addr,
  output logic                chk_hit,
  output logic                empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   PTR_ONE   = (PW + 1)'(1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {C_IDLE, C_W, C_B} cap_state_e;
  typedef enum logic [1:0] {D_IDLE, D_AW, D_W, D_B} drn_state_e;

  cap_state_e      c_state_q, c_state_d;
  drn_state_e      d_state_q, d_state_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d, dbeat_q, dbeat_d;
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     addr_d [DEPTH];
  logic [7:0]      len_q  [DEPTH];
  logic [7:0]      len_d  [DEPTH];
  logic [2:0]      size_q [DEPTH];
  logic [2:0]      size_d [DEPTH];
  logic [31:0]     data_q [DEPTH][LINE_WORDS];
  logic [31:0]     data_d [DEPTH][LINE_WORDS];
  logic [3:0]      strb_q [DEPTH][LINE_WORDS];
  logic [3:0]      strb_d [DEPTH][LINE_WORDS];
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [PW:0]     count_s;
  logic [PW-1:0]   wr_idx_s, rd_idx_s;
  logic            room_s, commit_s, pop_s, last_s, chk_hit_s;
  logic            unused_s;

  assign count_s  = wr_ptr_q - rd_ptr_q;
  assign wr_idx_s = wr_ptr_q[PW-1:0];
  assign rd_idx_s = rd_ptr_q[PW-1:0];
  assign room_s   = (count_s < DEPTH_C);
  assign unused_s = ^chk_addr[OFF-1:0];

  // Capture FSM: accept one burst into slot wr_ptr and answer B locally.
  always_comb begin
    c_state_d     = c_state_q;
    wr_ptr_d      = wr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    addr_d        = addr_q;
    len_d         = len_q;
    size_d        = size_q;
    data_d        = data_q;
    strb_d        = strb_q;
    commit_s      = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (c_state_q)
      C_IDLE: begin
        s_axi.awready = room_s;
        if (s_axi.awvalid && room_s) begin
          addr_d[wr_idx_s] = s_axi.awaddr;
          len_d[wr_idx_s]  = s_axi.awlen;
          size_d[wr_idx_s] = s_axi.awsize;
          beat_cnt_d       = {BW{1'b0}};
          c_state_d        = C_W;
        end else begin
          c_state_d = C_IDLE;
        end
      end
      C_W: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid) begin
          // Over-long bursts keep overwriting the last slot.
          data_d[wr_idx_s][beat_cnt_q] = s_axi.wdata;
          strb_d[wr_idx_s][beat_cnt_q] = s_axi.wstrb;
          beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? beat_cnt_q : beat_cnt_q + BEAT_ONE;
          if (s_axi.wlast) begin
            commit_s  = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            c_state_d = C_B;
          end else begin
            c_state_d = C_W;
          end
        end else begin
          c_state_d = C_W;
        end
      end
      C_B: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) begin
          c_state_d = C_IDLE;
        end else begin
          c_state_d = C_B;
        end
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  // Drain FSM: replay the oldest committed entry as an AW/W/B transaction.
  always_comb begin
    d_state_d      = d_state_q;
    rd_ptr_d       = rd_ptr_q;
    dbeat_d        = dbeat_q;
    pop_s          = 1'b0;
    last_s         = (8'(dbeat_q) == len_q[rd_idx_s]);
    m_axi.awaddr   = 32'h0;
    m_axi.awlen    = 8'h0;
    m_axi.awsize   = 3'h0;
    m_axi.awvalid  = 1'b0;
    m_axi.wdata    = 32'h0;
    m_axi.wstrb    = 4'h0;
    m_axi.wlast    = 1'b0;
    m_axi.wvalid   = 1'b0;
    m_axi.bready   = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (count_s != {(PW + 1){1'b0}}) begin
          d_state_d = D_AW;
        end else begin
          d_state_d = D_IDLE;
        end
      end
      D_AW: begin
        m_axi.awvalid = 1'b1;
        m_axi.awaddr  = addr_q[rd_idx_s];
        m_axi.awlen   = len_q[rd_idx_s];
        m_axi.awsize  = size_q[rd_idx_s];
        if (m_axi.awready) begin
          dbeat_d   = {BW{1'b0}};
          d_state_d = D_W;
        end else begin
          d_state_d = D_AW;
        end
      end
      D_W: begin
        m_axi.wvalid = 1'b1;
        m_axi.wdata  = data_q[rd_idx_s][dbeat_q];
        m_axi.wstrb  = strb_q[rd_idx_s][dbeat_q];
        m_axi.wlast  = last_s;
        if (m_axi.wready && last_s) begin
          d_state_d = D_B;
        end else if (m_axi.wready) begin
          dbeat_d   = (dbeat_q == LAST_BEAT) ? dbeat_q : dbeat_q + BEAT_ONE;
          d_state_d = D_W;
        end else begin
          d_state_d = D_W;
        end
      end
      D_B: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          pop_s     = 1'b1;
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          d_state_d = D_IDLE;
        end else begin
          d_state_d = D_B;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  // Valid bits: set on commit, cleared on downstream completion.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = (valid_q[i] | (commit_s && (wr_idx_s == PW'(i))))
                 & ~(pop_s && (rd_idx_s == PW'(i)));
    end
  end

  // Line-granular hazard match; the entry being captured counts as buffered.
  always_comb begin
    chk_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((valid_q[i] || ((c_state_q == C_W) && (wr_idx_s == PW'(i)))) &&
          (addr_q[i][31:OFF] == chk_addr[31:OFF])) begin
        chk_hit_s = 1'b1;
      end else begin
        chk_hit_s = chk_hit_s;
      end
    end
  end

  assign chk_hit = chk_hit_s;
  assign empty   = (count_s == {(PW + 1){1'b0}}) && (c_state_q == C_IDLE) && (d_state_q == D_IDLE);

  // State, pointer and storage registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      c_state_q  <= C_IDLE;
      d_state_q  <= D_IDLE;
      wr_ptr_q   <= {(PW + 1){1'b0}};
      rd_ptr_q   <= {(PW + 1){1'b0}};
      beat_cnt_q <= {BW{1'b0}};
      dbeat_q    <= {BW{1'b0}};
      valid_q    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 32'h0;
        len_q[i]  <= 8'h0;
        size_q[i] <= 3'h0;
        for (int j = 0; j < LINE_WORDS; j++) begin
          data_q[i][j] <= 32'h0;
          strb_q[i][j] <= 4'h0;
        end
      end
    end else begin
      c_state_q  <= c_state_d;
      d_state_q  <= d_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      dbeat_q    <= dbeat_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
    end
  end

endmodule

// File: tb/tb_dcache_wbuf.sv
// Directed plus randomized bench for dcache_wbuf; downstream traffic is checked
// against a FIFO of the bursts the D-cache side sent.
module tb_dcache_wbuf;
  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] chk_addr;
  logic        chk_hit;
  logic        empty;

  always #5 clk = ~clk;

  dcache_wbuf_if s_if ();
  dcache_wbuf_if m_if ();

  dcache_wbuf #(.LINE_WORDS(LW), .DEPTH(2)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .s_axi   (s_if),
    .m_axi   (m_if),
    .chk_addr(chk_addr),
    .chk_hit (chk_hit),
    .empty   (empty)
  );

  typedef struct packed {
    logic [31:0]          addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [LW-1:0][31:0]  data;
    logic [LW-1:0][3:0]   strb;
  } burst_t;

  burst_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     b_owed = 0;
  bit     b_hs   = 1'b0;
  int     stall_pct = 0;
  bit     aw_hold = 1'b0, w_hold = 1'b0, b_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step; downstream ready/response lines are refreshed after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (b_hs) begin
      m_if.bvalid = 1'b0;
      b_owed--;
      b_hs = 1'b0;
    end
    if (!m_if.bvalid && b_owed > 0 && !b_hold && ($urandom_range(99) >= stall_pct))
      m_if.bvalid = 1'b1;
    m_if.awready = !aw_hold && ($urandom_range(99) >= stall_pct);
    m_if.wready  = !w_hold  && ($urandom_range(99) >= stall_pct);
  endtask

  task automatic send_burst(input logic [31:0] addr, input logic [7:0] len,
                            input bit seq, input logic [3:0] strb, input bit rnd_strb);
    burst_t b;
    bit hs;
    int n;
    b = '0;
    b.addr = addr;
    b.len  = len;
    b.size = rnd_strb ? 3'($urandom_range(7)) : 3'd2;
    for (int i = 0; i <= int'(len); i++) begin
      b.data[i] = seq ? 32'(i) : $urandom;
      b.strb[i] = rnd_strb ? 4'($urandom_range(15)) : strb;
    end
    exp_q.push_back(b);
    s_if.awaddr = addr; s_if.awlen = len; s_if.awsize = b.size; s_if.awvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 500) begin @(negedge clk); hs = s_if.awready; tick(); n++; end
    s_if.awvalid = 1'b0;
    check("s_aw_accept", 64'(hs), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      s_if.wdata = b.data[i]; s_if.wstrb = b.strb[i];
      s_if.wlast = (i == int'(len)); s_if.wvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 50) begin @(negedge clk); hs = s_if.wready; tick(); n++; end
      if (!hs) check("s_w_accept", 64'(hs), 64'd1);
    end
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    check("s_bvalid_after_wlast", 64'(s_if.bvalid), 64'd1);
    s_if.bready = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin @(negedge clk); hs = s_if.bvalid; tick(); n++; end
    s_if.bready = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      if (empty && exp_q.size() == 0 && b_owed == 0) done = 1'b1;
      else tick();
    end
    check("drain_to_empty", 64'(done), 64'd1);
  endtask

  // Downstream monitor: scoreboard compare and valid/payload hold rules.
  initial begin
    burst_t cur;
    int mbeat;
    bit aw_pend, w_pend;
    logic [42:0] aw_pay;
    logic [36:0] w_pay;
    cur = '0; mbeat = 0; aw_pend = 1'b0; w_pend = 1'b0; aw_pay = '0; w_pay = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_pend = 1'b0; w_pend = 1'b0;
      end else begin
        if (aw_pend) begin
          check("awvalid_hold", 64'(m_if.awvalid), 64'd1);
          check("aw_payload_hold", 64'({m_if.awaddr, m_if.awlen, m_if.awsize}), 64'(aw_pay));
        end
        if (w_pend) begin
          check("wvalid_hold", 64'(m_if.wvalid), 64'd1);
          check("w_payload_hold", 64'({m_if.wdata, m_if.wstrb, m_if.wlast}), 64'(w_pay));
        end
        aw_pend = m_if.awvalid && !m_if.awready;
        aw_pay  = {m_if.awaddr, m_if.awlen, m_if.awsize};
        w_pend  = m_if.wvalid && !m_if.wready;
        w_pay   = {m_if.wdata, m_if.wstrb, m_if.wlast};
        if (m_if.awvalid && m_if.awready) begin
          check("aw_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          check("m_awaddr", 64'(m_if.awaddr), 64'(cur.addr));
          check("m_awlen",  64'(m_if.awlen),  64'(cur.len));
          check("m_awsize", 64'(m_if.awsize), 64'(cur.size));
          mbeat = 0;
        end
        if (m_if.wvalid && m_if.wready) begin
          check("m_wdata", 64'(m_if.wdata), 64'(cur.data[mbeat % LW]));
          check("m_wstrb", 64'(m_if.wstrb), 64'(cur.strb[mbeat % LW]));
          check("m_wlast", 64'(m_if.wlast), 64'(mbeat == int'(cur.len)));
          if (m_if.wlast) b_owed++;
          mbeat++;
        end
        if (m_if.bvalid && m_if.bready) b_hs = 1'b1;
      end
    end
  end

  initial begin
    bit hs, seen;
    rst_n = 1'b0; chk_addr = 32'h0;
    s_if.awaddr = 32'h0; s_if.awlen = 8'h0; s_if.awsize = 3'h0; s_if.awvalid = 1'b0;
    s_if.wdata = 32'h0; s_if.wstrb = 4'h0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0; s_if.bready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_s_awready", 64'(s_if.awready), 64'd1);
    check("rst_s_wready",  64'(s_if.wready),  64'd0);
    check("rst_s_bvalid",  64'(s_if.bvalid),  64'd0);
    check("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("rst_m_wvalid",  64'(m_if.wvalid),  64'd0);
    check("rst_m_bready",  64'(m_if.bready),  64'd0);
    check("rst_m_data",    64'({m_if.awaddr, m_if.wdata}), 64'd0);
    check("rst_chk_hit",   64'(chk_hit), 64'd0);
    check("rst_empty",     64'(empty),   64'd1);

    // Single 8-beat eviction, downstream always ready.
    tick();
    send_burst(32'h1FC0_0100, 8'd7, 1'b1, 4'hF, 1'b0);
    check("drain_start_latency", 64'(m_if.awvalid), 64'd1);
    wait_idle();
    check("empty_after_drain", 64'(empty), 64'd1);

    // Uncached partial store.
    send_burst(32'h1FAF_F000, 8'd0, 1'b0, 4'b0011, 1'b0);
    wait_idle();

    // Fill both entries with AW blocked, then see room reopen after one pop.
    aw_hold = 1'b1;
    tick();
    send_burst(32'h0000_4000, 8'd3, 1'b0, 4'hF, 1'b0);
    send_burst(32'h0000_5020, 8'd1, 1'b0, 4'hA, 1'b0);
    s_if.awaddr = 32'h0000_6000; s_if.awlen = 8'd2; s_if.awvalid = 1'b1;
    repeat (3) tick();
    check("full_awready_low", 64'(s_if.awready), 64'd0);
    check("full_not_empty", 64'(empty), 64'd0);
    aw_hold = 1'b0;
    hs = 1'b0;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = m_if.bvalid && m_if.bready;
      tick();
    end
    check("first_pop_seen", 64'(hs), 64'd1);
    check("awready_after_pop", 64'(s_if.awready), 64'd1);
    send_burst(32'h0000_6000, 8'd2, 1'b0, 4'hF, 1'b0);
    wait_idle();

    // Hazard on a buffered line, held through the downstream B phase.
    aw_hold = 1'b1;
    send_burst(32'h0000_2040, 8'd7, 1'b0, 4'hF, 1'b0);
    chk_addr = 32'h0000_205C; #1;
    check("hazard_same_line", 64'(chk_hit), 64'd1);
    chk_addr = 32'h0000_2060; #1;
    check("hazard_next_line", 64'(chk_hit), 64'd0);
    chk_addr = 32'h0000_205C;
    b_hold = 1'b1; aw_hold = 1'b0;
    hs = 1'b0;
    for (int n = 0; n < 100 && !hs; n++) begin tick(); hs = m_if.bready; end
    check("reached_b_phase", 64'(hs), 64'd1);
    repeat (3) begin
      tick();
      check("hazard_in_b_phase", 64'({m_if.bready, chk_hit}), 64'd3);
    end
    b_hold = 1'b0;
    wait_idle();
    check("hazard_cleared", 64'(chk_hit), 64'd0);

    // Randomized bursts with downstream stalls.
    stall_pct = 35;
    for (int k = 0; k < 50; k++)
      send_burst($urandom & 32'hFFFF_FFFC, 8'($urandom_range(LW - 1)), 1'b0, 4'h0, 1'b1);
    wait_idle();
    stall_pct = 0;

    // Reset during the downstream W phase after three beats.
    aw_hold = 1'b1;
    send_burst(32'h0000_8000, 8'd7, 1'b1, 4'hF, 1'b0);
    w_hold = 1'b1; aw_hold = 1'b0;
    hs = 1'b0;
    for (int n = 0; n < 50 && !hs; n++) begin tick(); hs = m_if.wvalid; end
    check("reached_w_phase", 64'(hs), 64'd1);
    w_hold = 1'b0; m_if.wready = 1'b1;
    tick(); tick();
    w_hold = 1'b1;
    tick();
    check("mid_burst_wvalid", 64'(m_if.wvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wvalid", 64'(m_if.wvalid), 64'd0);
    check("async_rst_bready", 64'(m_if.bready), 64'd0);
    check("async_rst_wdata",  64'(m_if.wdata),  64'd0);
    check("async_rst_empty",  64'(empty),       64'd1);
    exp_q.delete(); b_owed = 0; b_hs = 1'b0; m_if.bvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    w_hold = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | m_if.wvalid | m_if.awvalid;
    end
    check("no_traffic_after_reset", 64'(seen), 64'd0);
    check("empty_after_reset", 64'(empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
